// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a multiplexed 4-digit 7-segment scan back into BCD digits.
//
// Ports
//   clk_500     sampling clock, rising edge
//   rst_n       asynchronous active-low reset
//   bitchose    digit select, one-hot (0001=fir .. 1000=fou), 0000=blank
//   num         segment pattern, bit6..bit0 = a..g, active-high
//   fir..fou    BCD digits of the last committed frame (4'hF = not a decimal glyph)
//   digit_err   per-digit "not a decimal glyph" flags of the last committed frame
//   frame_valid one-cycle pulse when a new frame is committed
//   scan_err    one-cycle pulse on scan order violation or multi-hot select
//   stale       level, no accepted symbol for TIMEOUT cycles (cleared by next commit)
module seg_scan_decoder #(
    parameter int unsigned STABLE_CNT = 1,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic       clk_500,
    input  logic       rst_n,
    input  logic [3:0] bitchose,
    input  logic [6:0] num,
    output logic [3:0] fir,
    output logic [3:0] sec,
    output logic [3:0] thi,
    output logic [3:0] fou,
    output logic [3:0] digit_err,
    output logic       frame_valid,
    output logic       scan_err,
    output logic       stale
);

    localparam logic [3:0] STB_MAX = 4'(STABLE_CNT);
    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

    typedef enum logic [0:0] {StHunt, StCapture} state_t;

    logic [3:0] sel_q, prev_sel_q, last_acc_q;
    logic [6:0] num_q;
    logic [3:0] run_q, run_d;
    logic [7:0] tmo_q, tmo_d;
    state_t     state_q, state_d;
    logic [1:0] exp_q, exp_d;
    logic [3:0] buf_dig_q [4];
    logic [3:0] buf_dig_d [4];
    logic [3:0] buf_err_q, buf_err_d;
    logic       stale_d;

    logic       sel_onehot, sel_multi, accept, commit, err_pulse;
    logic [1:0] sel_idx;
    logic [3:0] dec_dig;
    logic       dec_err;

    assign sel_multi  = (sel_q & (sel_q - 4'd1)) != 4'b0;
    assign sel_onehot = (sel_q != 4'b0) && !sel_multi;

    always_comb begin
        sel_idx = 2'd0;
        case (sel_q)
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

    always_comb begin
        dec_dig = 4'hF;
        dec_err = 1'b0;
        case (num_q)
            7'b1111110: dec_dig = 4'd0;
            7'b0110000: dec_dig = 4'd1;
            7'b1101101: dec_dig = 4'd2;
            7'b1111001: dec_dig = 4'd3;
            7'b0110011: dec_dig = 4'd4;
            7'b1011011: dec_dig = 4'd5;
            7'b1011111: dec_dig = 4'd6;
            7'b1110000: dec_dig = 4'd7;
            7'b1111111: dec_dig = 4'd8;
            7'b1111011: dec_dig = 4'd9;
            default: begin
                dec_dig = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    // Run length of the current one-hot select, including this sample; blank or
    // multi-hot restarts it.
    always_comb begin
        run_d = 4'd0;
        if (sel_onehot) begin
            if (sel_q == prev_sel_q && run_q != 4'd0) begin
                run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
            end else begin
                run_d = 4'd1;
            end
        end
    end

    assign accept = sel_onehot && (run_d >= STB_MAX) && (sel_q != last_acc_q);

    always_comb begin
        tmo_d = 8'd0;
        if (!accept) begin
            tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 8'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        buf_dig_d = buf_dig_q;
        buf_err_d = buf_err_q;
        commit    = 1'b0;
        err_pulse = 1'b0;
        if (sel_multi) begin
            err_pulse = 1'b1;
            state_d   = StHunt;
        end else if (accept) begin
            case (state_q)
                StHunt: begin
                    if (sel_idx == 2'd0) begin
                        buf_dig_d[0] = dec_dig;
                        buf_err_d[0] = dec_err;
                        exp_d        = 2'd1;
                        state_d      = StCapture;
                    end
                end
                StCapture: begin
                    if (sel_idx == exp_q) begin
                        buf_dig_d[sel_idx] = dec_dig;
                        buf_err_d[sel_idx] = dec_err;
                        commit             = (exp_q == 2'd3);
                        exp_d              = exp_q + 2'd1;
                    end else begin
                        err_pulse = 1'b1;
                        if (sel_idx == 2'd0) begin
                            buf_dig_d[0] = dec_dig;
                            buf_err_d[0] = dec_err;
                            exp_d        = 2'd1;
                        end else begin
                            state_d = StHunt;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end else if (tmo_d == TMO_MAX) begin
            // Scan went quiet: drop any partial frame silently.
            state_d = StHunt;
        end
    end

    always_comb begin
        stale_d = stale;
        if (commit) begin
            stale_d = 1'b0;
        end else if (tmo_d == TMO_MAX) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk_500 or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= 4'b0;
            num_q       <= 7'b0;
            prev_sel_q  <= 4'b0;
            run_q       <= 4'd0;
            last_acc_q  <= 4'b0;
            tmo_q       <= 8'd0;
            state_q     <= StHunt;
            exp_q       <= 2'd0;
            buf_dig_q   <= '{default: 4'hF};
            buf_err_q   <= 4'b0;
            fir         <= 4'hF;
            sec         <= 4'hF;
            thi         <= 4'hF;
            fou         <= 4'hF;
            digit_err   <= 4'b0;
            frame_valid <= 1'b0;
            scan_err    <= 1'b0;
            stale       <= 1'b1;
        end else begin
            sel_q      <= bitchose;
            num_q      <= num;
            prev_sel_q <= sel_q;
            run_q      <= run_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            exp_q      <= exp_d;
            buf_dig_q  <= buf_dig_d;
            buf_err_q  <= buf_err_d;
            if (accept) begin
                last_acc_q <= sel_q;
            end
            if (commit) begin
                fir       <= buf_dig_d[0];
                sec       <= buf_dig_d[1];
                thi       <= buf_dig_d[2];
                fou       <= buf_dig_d[3];
                digit_err <= buf_err_d;
            end
            frame_valid <= commit;
            scan_err    <= err_pulse && !commit;
            stale       <= stale_d;
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CNT, default 1: consecutive identical samples of bitchose needed to accept a digit symbol (range 1-15).
REQ-002 Parameter TIMEOUT, default 16: cycles without an accepted symbol before stale is asserted (range 2-255).
REQ-003 clk_500  in  1  sampling clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 bitchose  in  4  digit select, active-high one-hot: 0001=fir, 0010=sec, 0100=thi, 1000=fou; 0000=blank.
REQ-006 num  in  7  segment pattern, active-high, bit6..bit0 = a..g.
REQ-007 fir, sec, thi, fou  out  4 each  decoded BCD digits of the last complete frame.
REQ-008 digit_err  out  4  per-digit flag (bit0=fir .. bit3=fou): the pattern for that digit was not a decimal glyph.
REQ-009 frame_valid  out  1  one-cycle pulse: a new complete frame has been committed.
REQ-010 scan_err  out  1  one-cycle pulse: scan order violation or illegal select.
REQ-011 stale  out  1  level: no valid scan activity for TIMEOUT cycles.

Function
REQ-012 Inputs shall be registered once before any use (1 cycle input latency); all outputs shall be registered.
REQ-013 Symbol acceptance: a symbol shall be accepted when a one-hot bitchose value different from the last accepted select has been sampled STABLE_CNT consecutive cycles; num is captured in the acceptance cycle.
REQ-014 The same select held after acceptance shall not be re-accepted until a different value is sampled.
REQ-015 bitchose=0000 shall be ignored: no acceptance, no error; it resets the stability count and does not reset the timeout counter.
REQ-016 Glyph decode (num -> BCD): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
REQ-017 Any other pattern, including 0000001 (dash) and 0000000, shall decode to 4'hF with the corresponding digit_err bit set in the committed frame.
REQ-018 FSM states: HUNT (wait for an accepted select 0001) and CAPTURE (expect index k, k = 1..3 then back to 0).
REQ-019 HUNT: acceptance of 0001 -> store digit 0, go to CAPTURE expecting index 1; acceptance of any other one-hot select -> remain in HUNT, no error.
REQ-020 CAPTURE: acceptance of the expected index -> store digit and advance; after storing index 3, commit the frame and expect index 0.
REQ-021 CAPTURE, out-of-order one-hot select: pulse scan_err and discard the partial frame; if that select is 0001, store digit 0 and expect index 1, otherwise go to HUNT.
REQ-022 A sampled bitchose with more than one bit set shall pulse scan_err in the cycle after sampling, discard the partial frame, and go to HUNT.
REQ-023 Commit: in the cycle after index 3 is accepted, update fir..fou and digit_err atomically and pulse frame_valid; outputs hold between commits.
REQ-024 Timeout counter: cleared on every acceptance and incremented otherwise, saturating at TIMEOUT. On reaching TIMEOUT: stale=1, partial frame discarded, state HUNT, no scan_err.
REQ-025 stale shall clear in the same cycle as the next frame_valid pulse.
REQ-026 If scan_err and a commit coincide, the commit takes precedence; scan_err is not asserted and the frame is committed.

Reset
REQ-027 While rst_n=0: fir..fou=4'hF, digit_err=4'b0000, frame_valid=0, scan_err=0, stale=1, FSM=HUNT, last accepted select=0000, all counters=0.
REQ-028 Reset asserted mid-frame shall discard the partial frame; no frame_valid is produced by digits captured before reset.

Verification
REQ-029 Bench shall drive the scan 0001/1111110, 0010/0110000, 0100/1101101, 1000/1111001 at one symbol per cycle. Required: frame_valid pulse one cycle after the fou symbol is accepted, fir..fou=0,1,2,3, digit_err=0000, stale=0.
REQ-030 Bench shall drive a frame whose thi pattern is 0000001. Required: thi=4'hF, digit_err=0100, other digits correct, frame_valid pulses.
REQ-031 Bench shall drive the order 0001, 0010, 1000. Required: scan_err pulse, no frame_valid, FSM in HUNT; a following clean frame commits correctly.
REQ-032 Bench shall drive bitchose=0011 mid-frame. Required: scan_err pulse, partial frame discarded, outputs unchanged.
REQ-033 Bench shall hold bitchose=0000 for TIMEOUT cycles after a good frame. Required: stale=1, digits retained; the next good frame clears stale together with frame_valid.
REQ-034 Bench shall assert rst_n=0 after two symbols of a frame, then release it and send a full frame. Required: reset values during reset, and exactly one frame_valid pulse, for the new frame only.
